// File: rtl/gate_tt_checker.sv
// ============================================================================
// Module      : gate_tt_checker
// Description : Truth-table sequencer/checker for small combinational gates.
//               Sweeps all input vectors, samples the gate and reports pass/fail.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_tt_checker #(
    parameter int                    N_IN   = 2,
    parameter logic [2**N_IN-1:0]    TRUTH  = 4'b1000,
    parameter int                    SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] vec_out,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail_vec
);

    localparam logic [N_IN-1:0] c_last_vec  = {N_IN{1'b1}};
    localparam logic [7:0]      c_hold_last = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state, w_state_nx;
    logic [N_IN-1:0] r_vec, w_vec_nx;
    logic [N_IN-1:0] r_ffv, w_ffv_nx;
    logic [7:0]      r_hold, w_hold_nx;
    logic [N_IN:0]   r_err, w_err_nx;
    logic            r_pass, w_pass_nx;
    logic            w_mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_vec   <= '0;
            r_ffv   <= '0;
            r_hold  <= '0;
            r_err   <= '0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_vec   <= w_vec_nx;
            r_ffv   <= w_ffv_nx;
            r_hold  <= w_hold_nx;
            r_err   <= w_err_nx;
            r_pass  <= w_pass_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_vec_nx   = r_vec;
        w_ffv_nx   = r_ffv;
        w_hold_nx  = r_hold;
        w_err_nx   = r_err;
        w_pass_nx  = r_pass;
        w_mismatch = (dut_out != TRUTH[r_vec]);

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx = S_DRIVE;
                    w_vec_nx   = '0;
                    w_hold_nx  = '0;
                    w_err_nx   = '0;
                    w_ffv_nx   = '0;
                    w_pass_nx  = 1'b0;
                end
            end
            S_DRIVE: begin
                if (r_hold == c_hold_last) begin
                    // Sample only on the last hold cycle so the gate has fully settled
                    if (w_mismatch) begin
                        w_err_nx = r_err + 1'b1;
                        if (r_err == '0) begin
                            w_ffv_nx = r_vec;
                        end
                    end
                    if (r_vec == c_last_vec) begin
                        w_state_nx = S_DONE;
                        w_vec_nx   = '0;
                        w_pass_nx  = (r_err == '0) && !w_mismatch;
                    end else begin
                        w_vec_nx  = r_vec + 1'b1;
                        w_hold_nx = '0;
                    end
                end else begin
                    w_hold_nx = r_hold + 8'd1;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign vec_out        = r_vec;
    assign busy           = (r_state == S_DRIVE);
    assign done           = (r_state == S_DONE);
    assign pass           = r_pass;
    assign err_count      = r_err;
    assign first_fail_vec = r_ffv;

endmodule

`default_nettype wire
